fp_round_unit: RTL and testbench

Rounding and exception-flag stage that sits downstream of the floating point functional units (div, mul, add) and receives their `float_t` result, guard/round/sticky bits and exception flags. It applies the selected RISC-V rounding mode and handles mantissa carry and post-rounding overflow. It holds results in a two-stage valid/ready pipeline toward writeback and produces the `fflags` exception bits.

---
 rtl/fp_round_unit_pkg.sv | 62 ++++++
 rtl/fp_round_unit_core.sv | 100 ++++++++++
 rtl/fp_round_unit.sv | 157 +++++++++++++++
 tb/tb_fp_round_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_round_unit_pkg.sv
// -----------------------------------------------------------------------------
// fp_round_unit_pkg
// Shared types and constants for the floating point rounding stage:
//   float_t       IEEE-754 single precision field view
//   fu_state_e    functional unit occupancy (FREE / BUSY)
//   round_mode_e  RISC-V rounding mode encodings (DYN selects the CSR mode)
//   fflags_t      exception flags {nv, dz, of, uf, nx}
//   stage_a_t     operand and side-band captured by the first pipeline stage
// -----------------------------------------------------------------------------
package fp_round_unit_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } round_mode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [31:0] Q_NAN         = 32'h7FC0_0000;
    localparam logic [31:0] CANONICAL_NAN = Q_NAN;
    localparam logic [31:0] P_MAX_FINITE  = 32'h7F7F_FFFF;
    localparam logic [31:0] P_INF         = 32'h7F80_0000;

    typedef struct packed {
        float_t     operand;
        logic [2:0] grs;
        logic       overflow;
        logic       underflow;
        logic       invalid_op;
        logic       zero_divide;
        logic [2:0] rm;
        logic [2:0] frm;
    } stage_a_t;

    // Only RNE..RMM are usable once DYN has been resolved.
    function automatic logic is_legal_mode(input logic [2:0] mode);
        return (mode == RNE) || (mode == RTZ) || (mode == RDN) ||
               (mode == RUP) || (mode == RMM);
    endfunction

endpackage

// File: rtl/fp_round_unit_core.sv
// -----------------------------------------------------------------------------
// fp_round_core
// Purely combinational rounding datapath: resolves the effective rounding
// mode, applies the round-up increment on {exponent, mantissa}, substitutes
// the mode-dependent overflow result and produces the exception flags.
// Ports:
//   operand_i      unrounded result (float_t)
//   grs_i          guard, round, sticky bits {G,R,S}
//   overflow_i / underflow_i / invalid_op_i / zero_divide_i
//                  exception flags from the functional unit
//   rm_i, frm_i    instruction rounding mode and CSR dynamic mode
//   result_o       rounded result (float_t)
//   fflags_o       {nv, dz, of, uf, nx} for this result
// -----------------------------------------------------------------------------
module fp_round_core
    import fp_round_unit_pkg::*;
(
    input  float_t     operand_i,
    input  logic [2:0] grs_i,
    input  logic       overflow_i,
    input  logic       underflow_i,
    input  logic       invalid_op_i,
    input  logic       zero_divide_i,
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    output float_t     result_o,
    output fflags_t    fflags_o
);

    logic [2:0]  eff_mode;
    logic        illegal;
    logic        special;
    logic        is_nan;
    logic        inexact;
    logic        round_up;
    logic        sat_max;
    logic        overflow;
    logic        ovf_to_inf;
    logic        nx;
    logic [30:0] mag_in;
    logic [30:0] mag_sum;

    always_comb begin
        eff_mode = (rm_i == DYN) ? frm_i : rm_i;
        illegal  = ~is_legal_mode(eff_mode);
        is_nan   = (operand_i.exponent == 8'hFF) && (operand_i.mantissa != '0);
        special  = (operand_i.exponent == 8'hFF) | invalid_op_i | zero_divide_i;
        inexact  = |grs_i;
        mag_in   = {operand_i.exponent, operand_i.mantissa};

        round_up = 1'b0;
        case (eff_mode)
            RNE:     round_up = grs_i[2] & (grs_i[1] | grs_i[0] | operand_i.mantissa[0]);
            RDN:     round_up = operand_i.sign & inexact;
            RUP:     round_up = ~operand_i.sign & inexact;
            RMM:     round_up = grs_i[2];
            default: round_up = 1'b0;
        endcase

        // Single 31-bit add so a full mantissa carries into the exponent.
        mag_sum = mag_in + {30'd0, round_up};

        // A max-finite magnitude with at least half an ulp discarded is taken
        // as overflowing in every mode, so the directed modes report OF when
        // they saturate to max finite instead of stepping to infinity.
        sat_max  = (mag_in == P_MAX_FINITE[30:0]) & grs_i[2];
        overflow = (mag_sum[30:23] == 8'hFF) | overflow_i | sat_max;

        ovf_to_inf = 1'b0;
        case (eff_mode)
            RNE, RMM: ovf_to_inf = 1'b1;
            RDN:      ovf_to_inf = operand_i.sign;
            RUP:      ovf_to_inf = ~operand_i.sign;
            default:  ovf_to_inf = 1'b0;
        endcase

        nx = overflow | inexact;

        result_o = operand_i;
        fflags_o = '0;
        if (illegal) begin
            result_o    = CANONICAL_NAN;
            fflags_o.nv = 1'b1;
        end else if (special) begin
            result_o    = (is_nan & invalid_op_i) ? CANONICAL_NAN : operand_i;
            fflags_o.nv = invalid_op_i;
            fflags_o.dz = zero_divide_i;
        end else begin
            if (overflow) begin
                result_o = {operand_i.sign, ovf_to_inf ? P_INF[30:0] : P_MAX_FINITE[30:0]};
            end else begin
                result_o = {operand_i.sign, mag_sum};
            end
            fflags_o.of = overflow;
            fflags_o.nx = nx;
            fflags_o.uf = underflow_i | ((mag_sum[30:23] == 8'h00) & nx);
        end
    end

endmodule

// File: rtl/fp_round_unit.sv
// -----------------------------------------------------------------------------
// fp_round_unit
// Rounding / exception-flag stage between the FP functional units and
// writeback. Two-entry valid/ready pipeline: stage A captures the unrounded
// operand, stage B holds the rounded result and its flags.
// Ports:
//   clk_i, rst_n_i (async, active-low), clk_en_i (global hold)
//   operand_i, grs_i, valid_i, ready_o        upstream handshake and data
//   overflow_i, underflow_i, invalid_op_i, zero_divide_i  upstream flags
//   rm_i, frm_i                               instruction / CSR rounding mode
//   result_o, valid_o, ready_i                writeback handshake and data
//   fflags_o                                  {NV,DZ,OF,UF,NX}
//   fflags_clear_i                            clear accumulated flags
//   fu_state_o                                FREE when both stages are empty
// Build option FFLAGS_ACCUM_EN: fflags_o becomes a sticky accumulator of the
// flags of every result accepted by writeback, cleared by fflags_clear_i.
// Without it fflags_o follows the stage-B result and fflags_clear_i is unused.
// -----------------------------------------------------------------------------
module fp_round_unit
    import fp_round_unit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clk_en_i,
    input  float_t     operand_i,
    input  logic [2:0] grs_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       overflow_i,
    input  logic       underflow_i,
    input  logic       invalid_op_i,
    input  logic       zero_divide_i,
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    output float_t     result_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [4:0] fflags_o,
    input  logic       fflags_clear_i,
    output fu_state_e  fu_state_o
);

    logic     a_valid_q, a_valid_d;
    stage_a_t a_data_q,  a_data_d;
    logic     b_valid_q, b_valid_d;
    float_t   b_result_q, b_result_d;
    fflags_t  b_flags_q,  b_flags_d;

    float_t   core_result;
    fflags_t  core_flags;

    logic     in_fire;
    logic     a_fire;
    logic     b_fire;

    fp_round_core u_core (
        .operand_i     (a_data_q.operand),
        .grs_i         (a_data_q.grs),
        .overflow_i    (a_data_q.overflow),
        .underflow_i   (a_data_q.underflow),
        .invalid_op_i  (a_data_q.invalid_op),
        .zero_divide_i (a_data_q.zero_divide),
        .rm_i          (a_data_q.rm),
        .frm_i         (a_data_q.frm),
        .result_o      (core_result),
        .fflags_o      (core_flags)
    );

    // A full pipe can still accept when writeback drains B this cycle,
    // since A then moves into B on the same edge.
    assign ready_o = ~a_valid_q | ~b_valid_q | ready_i;

    assign in_fire = valid_i & ready_o & clk_en_i;
    assign a_fire  = a_valid_q & (~b_valid_q | ready_i) & clk_en_i;
    assign b_fire  = b_valid_q & ready_i & clk_en_i;

    always_comb begin
        a_valid_d  = a_valid_q;
        a_data_d   = a_data_q;
        b_valid_d  = b_valid_q;
        b_result_d = b_result_q;
        b_flags_d  = b_flags_q;

        if (a_fire) begin
            b_valid_d  = 1'b1;
            b_result_d = core_result;
            b_flags_d  = core_flags;
        end else if (b_fire) begin
            b_valid_d  = 1'b0;
        end

        if (in_fire) begin
            a_valid_d            = 1'b1;
            a_data_d.operand     = operand_i;
            a_data_d.grs         = grs_i;
            a_data_d.overflow    = overflow_i;
            a_data_d.underflow   = underflow_i;
            a_data_d.invalid_op  = invalid_op_i;
            a_data_d.zero_divide = zero_divide_i;
            a_data_d.rm          = rm_i;
            a_data_d.frm         = frm_i;
        end else if (a_fire) begin
            a_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            b_valid_q  <= 1'b0;
            b_result_q <= '0;
            b_flags_q  <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            b_valid_q  <= b_valid_d;
            b_result_q <= b_result_d;
            b_flags_q  <= b_flags_d;
        end
    end

`ifdef FFLAGS_ACCUM_EN
    fflags_t acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clk_en_i) begin
            if (fflags_clear_i) begin
                acc_d = '0;
            end else if (b_fire) begin
                acc_d = acc_q | b_flags_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fflags_o = acc_q;
`else
    logic unused_fflags_clear;

    assign unused_fflags_clear = fflags_clear_i;
    assign fflags_o            = b_flags_q;
`endif

    assign result_o   = b_result_q;
    assign valid_o    = b_valid_q;
    assign fu_state_o = (a_valid_q | b_valid_q) ? BUSY : FREE;

endmodule

// File: tb/tb_fp_round_unit.sv
`timescale 1ns/1ps
module tb_fp_round_unit;
    import fp_round_unit_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic       clk_en_i = 1'b0;
    float_t     operand_i = '0;
    logic [2:0] grs_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       overflow_i = 1'b0;
    logic       underflow_i = 1'b0;
    logic       invalid_op_i = 1'b0;
    logic       zero_divide_i = 1'b0;
    logic [2:0] rm_i = '0;
    logic [2:0] frm_i = '0;
    float_t     result_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [4:0] fflags_o;
    logic       fflags_clear_i = 1'b0;
    fu_state_e  fu_state_o;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    int pops   = 0;

    logic [36:0] q [$];
    logic [4:0]  acc_m = '0;

    fp_round_unit dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .clk_en_i       (clk_en_i),
        .operand_i      (operand_i),
        .grs_i          (grs_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .overflow_i     (overflow_i),
        .underflow_i    (underflow_i),
        .invalid_op_i   (invalid_op_i),
        .zero_divide_i  (zero_divide_i),
        .rm_i           (rm_i),
        .frm_i          (frm_i),
        .result_o       (result_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .fflags_o       (fflags_o),
        .fflags_clear_i (fflags_clear_i),
        .fu_state_o     (fu_state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: returns {result[31:0], flags{nv,dz,of,uf,nx}} from the
    // rounding rules, working on the magnitude as a plain integer.
    function automatic logic [36:0] ref_round(input logic [31:0] op, input logic [2:0] grs,
                                              input logic ovf, input logic unf,
                                              input logic inv, input logic dz,
                                              input logic [2:0] rm, input logic [2:0] frm);
        int unsigned mode, mag, mag2, expo;
        logic sign, nx, of, uf, up, to_inf;
        logic [31:0] res;
        mode = (rm == 3'd7) ? frm : rm;
        sign = op[31];
        mag  = op[30:0];
        expo = op[30:23];
        if (mode > 4) return {32'h7FC00000, 5'b10000};
        if (expo == 255 || inv || dz) begin
            res = (inv && expo == 255 && op[22:0] != 0) ? 32'h7FC00000 : op;
            return {res, inv, dz, 3'b000};
        end
        nx = (grs != 0);
        case (mode)
            0:       up = (grs > 4) || (grs == 4 && (mag % 2) == 1);
            1:       up = 1'b0;
            2:       up = sign && nx;
            3:       up = !sign && nx;
            default: up = (grs >= 4);
        endcase
        mag2 = mag + (up ? 1 : 0);
        of = (mag2 >= 32'h7F800000) || ovf || (mag == 32'h7F7FFFFF && grs >= 4);
        if (of) begin
            nx = 1'b1;
            to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !sign) || (mode == 2 && sign);
            res = {sign, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
        end else begin
            res = {sign, mag2[30:0]};
        end
        uf = unf || (mag2 < 32'h00800000 && nx);
        return {res, 1'b0, 1'b0, of, uf, nx};
    endfunction

    // Scoreboard / compare process: outputs checked every cycle, model
    // updated with the handshakes that the coming edge will complete.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("idle_valid", {63'd0, valid_o}, 64'd0);
                end else begin
                    chk("result", {32'd0, result_o}, {32'd0, q[0][36:5]});
`ifndef FFLAGS_ACCUM_EN
                    chk("fflags", {59'd0, fflags_o}, {59'd0, q[0][4:0]});
`endif
                end
            end
            chk("ready_o", {63'd0, ready_o}, {63'd0, (q.size() < 2) || ready_i});
            chk("fu_state", {63'd0, fu_state_o}, {63'd0, (q.size() != 0) ? BUSY : FREE});
`ifdef FFLAGS_ACCUM_EN
            chk("fflags_acc", {59'd0, fflags_o}, {59'd0, acc_m});
`endif
            if (clk_en_i) begin
                if (valid_o && ready_i && q.size() != 0) begin
`ifdef FFLAGS_ACCUM_EN
                    acc_m = acc_m | q[0][4:0];
`endif
                    void'(q.pop_front());
                    pops++;
                end
`ifdef FFLAGS_ACCUM_EN
                if (fflags_clear_i) acc_m = '0;
`endif
                if (valid_i && ready_o) begin
                    q.push_back(ref_round(operand_i, grs_i, overflow_i, underflow_i,
                                          invalid_op_i, zero_divide_i, rm_i, frm_i));
                    n_vec++;
                end
            end
        end
    end

    // Directed vectors: op, grs, {ovf,unf,inv,dz}, rm, frm, expected result/flags.
    localparam int NV = 14;
    logic [31:0] t_op  [NV] = '{32'h3F800001, 32'h3F800000, 32'h3FFFFFFF, 32'h7F7FFFFF,
                                32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 32'h7FC00000,
                                32'h3F800000, 32'h3F800001, 32'h7F800001, 32'h00000001,
                                32'h3F800000, 32'hBF800000};
    logic [2:0]  t_grs [NV] = '{3'd4, 3'd4, 3'd6, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0,
                                3'd0, 3'd7, 3'd0, 3'd1, 3'd5, 3'd1};
    logic [3:0]  t_fl  [NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic [2:0]  t_rm  [NV] = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0,
                                3'd7, 3'd7, 3'd0, 3'd1, 3'd4, 3'd2};
    logic [2:0]  t_frm [NV] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                3'd5, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [31:0] t_res [NV] = '{32'h3F800002, 32'h3F800000, 32'h40000000, 32'h7F800000,
                                32'h7F7FFFFF, 32'hFF800000, 32'h7F800000, 32'h7FC00000,
                                32'h7FC00000, 32'h3F800001, 32'h7FC00000, 32'h00000001,
                                32'h3F800001, 32'hBF800001};
    logic [4:0]  t_ef  [NV] = '{5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00101, 5'b00101,
                                5'b01000, 5'b10000, 5'b10000, 5'b00001, 5'b10000, 5'b00011,
                                5'b00001, 5'b00001};

    task automatic drive_vec(input int i);
        operand_i     = t_op[i];
        grs_i         = t_grs[i];
        overflow_i    = t_fl[i][3];
        underflow_i   = t_fl[i][2];
        invalid_op_i  = t_fl[i][1];
        zero_divide_i = t_fl[i][0];
        rm_i          = t_rm[i];
        frm_i         = t_frm[i];
    endtask

    task automatic rand_inputs();
        int unsigned r;
        logic [7:0] e;
        r = $urandom();
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'h01;
            2:       e = 8'hFE;
            3:       e = 8'hFF;
            default: e = 8'($urandom_range(2, 253));
        endcase
        if ($urandom_range(0, 3) == 0) r[22:0] = 23'h7FFFFF;
        operand_i     = {r[31], e, r[22:0]};
        grs_i         = 3'($urandom_range(0, 7));
        overflow_i    = ($urandom_range(0, 11) == 0);
        underflow_i   = ($urandom_range(0, 11) == 0);
        invalid_op_i  = ($urandom_range(0, 11) == 0);
        zero_divide_i = ($urandom_range(0, 11) == 0);
        rm_i          = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        frm_i         = 3'($urandom_range(0, 7));
    endtask

    // Single transaction on an empty, unstalled pipe; called at posedge+1.
    task automatic send_check(input int i, input bit clr_on_pop);
        int n;
        clk_en_i = 1'b1;
        ready_i  = 1'b1;
        drive_vec(i);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk($sformatf("latency[%0d]", i), 64'(n), 64'd1);
        chk($sformatf("vec_result[%0d]", i), {32'd0, result_o}, {32'd0, t_res[i]});
`ifndef FFLAGS_ACCUM_EN
        chk($sformatf("vec_fflags[%0d]", i), {59'd0, fflags_o}, {59'd0, t_ef[i]});
`endif
        fflags_clear_i = clr_on_pop;
        @(posedge clk_i); #1;
        fflags_clear_i = 1'b0;
    endtask

    task automatic backpressure();
        int accepted = 0;
        int acc_at_drop = 0;
        int cyc = 0;
        int pops0;
        logic rdy_seen [8];
        pops0 = pops;
        clk_en_i = 1'b1;
        while (accepted < 4 && cyc < 8) begin
            rand_inputs();
            valid_i = 1'b1;
            ready_i = (cyc >= 3);
            @(negedge clk_i);
            rdy_seen[cyc] = ready_o;
            if (cyc == 2) acc_at_drop = accepted;
            if (ready_o) accepted++;
            @(posedge clk_i); #1;
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("bp_ready_drop", {63'd0, rdy_seen[2]}, 64'd0);
        chk("bp_accepted_before_drop", 64'(acc_at_drop), 64'd2);
        chk("bp_accepted", 64'(accepted), 64'd4);
        repeat (5) @(posedge clk_i);
        #1;
        chk("bp_results_out", 64'(pops - pops0), 64'd4);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_o"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_result_o"}, {32'd0, result_o}, 64'd0);
        chk({tag, "_fflags_o"}, {59'd0, fflags_o}, 64'd0);
        chk({tag, "_fu_state"}, {63'd0, fu_state_o}, {63'd0, FREE});
        chk({tag, "_ready_o"}, {63'd0, ready_o}, 64'd1);
    endtask

    initial begin
        #1 rst_n_i = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Pin the reference model to hand-computed values.
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("model[%0d]", i),
                {27'd0, ref_round(t_op[i], t_grs[i], t_fl[i][3], t_fl[i][2],
                                  t_fl[i][1], t_fl[i][0], t_rm[i], t_frm[i])},
                {27'd0, t_res[i], t_ef[i]});
        end

        for (int i = 0; i < NV; i++) send_check(i, 1'b0);

        backpressure();

        for (int c = 0; c < 4000; c++) begin
            rand_inputs();
            valid_i        = ($urandom_range(0, 9) < 7);
            ready_i        = ($urandom_range(0, 9) < 7);
            clk_en_i       = ($urandom_range(0, 9) != 0);
            fflags_clear_i = ($urandom_range(0, 19) == 0);
            @(posedge clk_i); #1;
        end

        valid_i = 1'b0;
        ready_i = 1'b1;
        clk_en_i = 1'b1;
        fflags_clear_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Reset with both stages occupied.
        ready_i = 1'b0;
        repeat (2) begin
            rand_inputs();
            valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        chk("pre_reset_valid", {63'd0, valid_o}, 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        acc_m = '0;
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i); #1;

`ifdef FFLAGS_ACCUM_EN
        send_check(0, 1'b0);
        send_check(4, 1'b0);
        chk("acc_nx_then_of", {59'd0, fflags_o}, 64'b00101);
        send_check(6, 1'b1);
        chk("acc_clear_wins", {59'd0, fflags_o}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
